// File: rtl/multicycle_control.sv
// Multicycle MIPS main control FSM: sequences fetch/decode/execute/memory/writeback, drives datapath controls.
// Optional PERF_CNT_EN adds cycle_cnt/instr_cnt perf counters; default build omits them.
module multicycle_control
`ifdef PERF_CNT_EN
#(
   parameter int CNT_WIDTH = 32
)
`endif
(
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic [5:0] i_opcode,
   input  logic [5:0] i_funct,
   input  logic       i_mem_ready,
   output logic       o_mem_read,
   output logic       o_mem_write,
   output logic       o_iord,
   output logic       o_ir_write,
   output logic       o_pc_write,
   output logic       o_pc_write_cond,
   output logic       o_branch_ne,
   output logic [1:0] o_pc_source,
   output logic       o_alu_src_a,
   output logic [1:0] o_alu_src_b,
   output logic [2:0] o_alu_op,
   output logic       o_reg_write,
   output logic       o_reg_dst,
   output logic       o_mem_to_reg,
`ifdef PERF_CNT_EN
   output logic       o_illegal_instr,
   output logic [CNT_WIDTH-1:0] o_cycle_cnt,
   output logic [CNT_WIDTH-1:0] o_instr_cnt
`else
   output logic       o_illegal_instr
`endif
);

   typedef enum logic [3:0] {
      S_IDLE     = 4'd0,
      S_FETCH    = 4'd1,
      S_DECODE   = 4'd2,
      S_MEM_ADDR = 4'd3,
      S_MEM_RD   = 4'd4,
      S_MEM_WB   = 4'd5,
      S_MEM_WR   = 4'd6,
      S_R_EXEC   = 4'd7,
      S_R_WB     = 4'd8,
      S_I_EXEC   = 4'd9,
      S_I_WB     = 4'd10,
      S_BRANCH   = 4'd11,
      S_JUMP     = 4'd12,
      S_JR       = 4'd13,
      S_TRAP     = 4'd14
   } state_t;

   typedef struct packed {
      logic       mem_read;
      logic       mem_write;
      logic       iord;
      logic       pc_write;
      logic       pc_write_cond;
      logic       branch_ne;
      logic [1:0] pc_source;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [2:0] alu_op;
      logic       reg_write;
      logic       reg_dst;
      logic       mem_to_reg;
      logic       illegal;
   } ctl_t;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_J    = 6'b000010;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_BNE  = 6'b000101;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_ORI  = 6'b001101;
   localparam logic [5:0] OP_LUI  = 6'b001111;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] FN_JR   = 6'b001000;

   function automatic state_t next_state(input state_t s, input logic [5:0] op,
                                         input logic [5:0] fn, input logic rdy);
      state_t n;
      n = S_IDLE;
      case (s)
         S_IDLE:     n = S_FETCH;
         S_FETCH:    n = rdy ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (op)
               OP_LW, OP_SW:            n = S_MEM_ADDR;
               OP_R:                    n = (fn == FN_JR) ? S_JR : S_R_EXEC;
               OP_ADDI, OP_ORI, OP_LUI: n = S_I_EXEC;
               OP_BEQ, OP_BNE:          n = S_BRANCH;
               OP_J:                    n = S_JUMP;
               default:                 n = S_TRAP;
            endcase
         end
         S_MEM_ADDR: n = (op == OP_SW) ? S_MEM_WR : S_MEM_RD;
         S_MEM_RD:   n = rdy ? S_MEM_WB : S_MEM_RD;
         S_MEM_WB:   n = S_FETCH;
         S_MEM_WR:   n = rdy ? S_FETCH : S_MEM_WR;
         S_R_EXEC:   n = S_R_WB;
         S_R_WB:     n = S_FETCH;
         S_I_EXEC:   n = S_I_WB;
         S_I_WB:     n = S_FETCH;
         S_BRANCH:   n = S_FETCH;
         S_JUMP:     n = S_FETCH;
         S_JR:       n = S_FETCH;
         S_TRAP:     n = S_TRAP;
         default:    n = S_IDLE;
      endcase
      return n;
   endfunction

   // Controls for the state being entered; opcode is stable from DECODE on, so lookahead is safe.
   function automatic ctl_t state_ctl(input state_t s, input logic [5:0] op);
      ctl_t c;
      c = '0;
      case (s)
         S_FETCH: begin
            c.mem_read  = 1'b1;
            c.alu_src_b = 2'b01;
            c.alu_op    = 3'b001;
         end
         S_DECODE: begin
            c.alu_src_b = 2'b11;
            c.alu_op    = 3'b001;
         end
         S_MEM_ADDR: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = 2'b10;
            c.alu_op    = 3'b001;
         end
         S_MEM_RD: begin
            c.mem_read = 1'b1;
            c.iord     = 1'b1;
         end
         S_MEM_WB: begin
            c.reg_write  = 1'b1;
            c.mem_to_reg = 1'b1;
         end
         S_MEM_WR: begin
            c.mem_write = 1'b1;
            c.iord      = 1'b1;
         end
         S_R_EXEC: begin
            c.alu_src_a = 1'b1;
            c.alu_op    = 3'b111;
         end
         S_R_WB: begin
            c.reg_write = 1'b1;
            c.reg_dst   = 1'b1;
         end
         S_I_EXEC: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = 2'b10;
            case (op)
               OP_ORI:  c.alu_op = 3'b101;
               OP_LUI:  c.alu_op = 3'b110;
               default: c.alu_op = 3'b100;
            endcase
         end
         S_I_WB:   c.reg_write = 1'b1;
         S_BRANCH: begin
            c.alu_src_a     = 1'b1;
            c.alu_op        = 3'b010;
            c.pc_write_cond = 1'b1;
            c.pc_source     = 2'b01;
            c.branch_ne     = op[0];
         end
         S_JUMP: begin
            c.pc_write  = 1'b1;
            c.pc_source = 2'b10;
         end
         S_JR: begin
            c.pc_write  = 1'b1;
            c.pc_source = 2'b11;
         end
         S_TRAP:   c.illegal = 1'b1;
         default:  c = '0;
      endcase
      return c;
   endfunction

   state_t r_state;
   ctl_t   r_ctl;
   state_t w_next;
   logic   w_fetch_done;

   assign w_next = next_state(r_state, i_opcode, i_funct, i_mem_ready);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= S_IDLE;
         r_ctl   <= '0;
      end else begin
         r_state <= w_next;
         r_ctl   <= state_ctl(w_next, i_opcode);
      end
   end

   // IR/PC load must land on the very cycle memory answers, so it bypasses the registered controls.
   assign w_fetch_done    = (r_state == S_FETCH) && i_mem_ready;

   assign o_mem_read      = r_ctl.mem_read;
   assign o_mem_write     = r_ctl.mem_write;
   assign o_iord          = r_ctl.iord;
   assign o_ir_write      = w_fetch_done;
   assign o_pc_write      = r_ctl.pc_write | w_fetch_done;
   assign o_pc_write_cond = r_ctl.pc_write_cond;
   assign o_branch_ne     = r_ctl.branch_ne;
   assign o_pc_source     = r_ctl.pc_source;
   assign o_alu_src_a     = r_ctl.alu_src_a;
   assign o_alu_src_b     = r_ctl.alu_src_b;
   assign o_alu_op        = r_ctl.alu_op;
   assign o_reg_write     = r_ctl.reg_write;
   assign o_reg_dst       = r_ctl.reg_dst;
   assign o_mem_to_reg    = r_ctl.mem_to_reg;
   assign o_illegal_instr = r_ctl.illegal;

`ifdef PERF_CNT_EN
   logic [CNT_WIDTH-1:0] r_cycle_cnt;
   logic [CNT_WIDTH-1:0] r_instr_cnt;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cycle_cnt <= '0;
         r_instr_cnt <= '0;
      end else begin
         if (r_state != S_IDLE && r_state != S_TRAP)
            r_cycle_cnt <= r_cycle_cnt + CNT_WIDTH'(1);
         if (w_next == S_FETCH && r_state != S_IDLE && r_state != S_FETCH)
            r_instr_cnt <= r_instr_cnt + CNT_WIDTH'(1);
      end
   end

   assign o_cycle_cnt = r_cycle_cnt;
   assign o_instr_cnt = r_instr_cnt;
`endif

endmodule
